// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the RV32I instruction encoder/loader: class codes,
// opcodes, the halt word, FSM states and an immediate range helper.
package enc_pkg;

  localparam logic [2:0] CLS_LW  = 3'd0;
  localparam logic [2:0] CLS_SW  = 3'd1;
  localparam logic [2:0] CLS_R   = 3'd2;
  localparam logic [2:0] CLS_BEQ = 3'd3;
  localparam logic [2:0] CLS_I   = 3'd4;
  localparam logic [2:0] CLS_JAL = 3'd5;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // jal x0,0: the core spins here once the program has run
  localparam logic [31:0] HALT_WORD = 32'h0000006F;

  // Bits that must all equal the sign bit for a 12b / 13b signed immediate
  localparam logic [20:0] MASK_IMM12 = 21'h1FF800;
  localparam logic [20:0] MASK_IMM13 = 21'h1FF000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HALT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic imm_fits(input logic [20:0] imm, input logic [20:0] hi_mask);
    return ((imm & hi_mask) == 21'h0) || ((imm & hi_mask) == hi_mask);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-input handshake and instruction-memory write port of the loader.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_cls;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [20:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_cls, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_cls, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader_packer.sv
// Combinational RV32I field packer. With ENC_RANGE_CHECK_EN defined, range_ok
// flags immediates that do not fit their field; otherwise it is always 1.
module instr_field_packer
  import enc_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        cls_ok,
  output logic        range_ok
);

  logic is_shift_s;
  assign is_shift_s = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Pack fields into the instruction format selected by cls
  always_comb begin
    word   = 32'h0;
    cls_ok = 1'b1;
    case (cls)
      CLS_LW:  word = {imm[11:0], rs1, 3'b010, rd, OP_LW};
      CLS_SW:  word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
      CLS_R:   word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      CLS_BEQ: word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BEQ};
      CLS_I: begin
        if (is_shift_s) begin
          word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OP_I};
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OP_I};
        end
      end
      CLS_JAL: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default: cls_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Immediate must fit its field; branch/jump targets must be halfword aligned
  always_comb begin
    range_ok = 1'b1;
    case (cls)
      CLS_LW, CLS_SW: range_ok = imm_fits(imm, MASK_IMM12);
      CLS_I: begin
        if (is_shift_s) begin
          range_ok = (imm[20:5] == 16'h0000);
        end else begin
          range_ok = imm_fits(imm, MASK_IMM12);
        end
      end
      CLS_BEQ: range_ok = imm_fits(imm, MASK_IMM13) && !imm[0];
      CLS_JAL: range_ok = !imm[0];
      default: range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instructions and writes them sequentially into instruction
// memory, closing each program with a halt word. Optional ENC_RANGE_CHECK_EN.
module instr_encoder_loader
  import enc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int unsigned       DEPTH     = 64,
  localparam int unsigned      CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 finish,
  instr_encoder_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        word_count,
  output logic                 err,
  output logic                 overflow
);

  // The final slot always stays free for the halt word
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [CW-1:0]     count_r, count_s;
  logic [31:0]       wdata_r, wdata_s;
  logic              we_r, we_s;
  logic              ready_r, ready_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              ovf_r, ovf_s;

  logic [31:0] word_s;
  logic        cls_ok_s;
  logic        range_ok_s;
  logic        word_ok_s;
  logic        accept_s;

  instr_field_packer u_packer (
    .cls      (bus.in_cls),
    .funct3   (bus.in_funct3),
    .funct7b5 (bus.in_funct7b5),
    .rd       (bus.in_rd),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .imm      (bus.in_imm),
    .word     (word_s),
    .cls_ok   (cls_ok_s),
    .range_ok (range_ok_s)
  );

  assign word_ok_s = cls_ok_s & range_ok_s;
  assign accept_s  = (state_r == ST_LOAD) && bus.in_valid && ready_r;

  // Next state, address, count and sticky flags
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    count_s = count_r;
    wdata_s = wdata_r;
    err_s   = err_r;
    ovf_s   = ovf_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_LOAD;
          addr_s  = BASE_ADDR;
          count_s = {CW{1'b0}};
          err_s   = 1'b0;
          ovf_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid && (count_r == LAST_SLOT)) begin
          ovf_s = 1'b1;
        end else begin
          ovf_s = ovf_r;
        end
        if (accept_s) begin
          if (word_ok_s) begin
            state_s = ST_WRITE;
            wdata_s = word_s;
          end else begin
            err_s = 1'b1;
          end
        end else if (finish) begin
          state_s = ST_HALT;
          wdata_s = HALT_WORD;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE, ST_HALT: begin
        addr_s  = addr_r + ADDR_W'(32'd4);
        count_s = count_r + CW'(1'b1);
        if (state_r == ST_WRITE) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    we_s    = (state_s == ST_WRITE) || (state_s == ST_HALT);
    ready_s = (state_s == ST_LOAD) && (count_s < LAST_SLOT);
    busy_s  = (state_s == ST_LOAD) || (state_s == ST_WRITE) || (state_s == ST_HALT);
    done_s  = (state_s == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      addr_r  <= BASE_ADDR;
      count_r <= {CW{1'b0}};
      wdata_r <= 32'h0;
      we_r    <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      count_r <= count_s;
      wdata_r <= wdata_s;
      we_r    <= we_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
      ovf_r   <= ovf_s;
    end
  end

  assign bus.in_ready   = ready_r;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign word_count     = count_r;
  assign err            = err_r;
  assign overflow       = ovf_r;

endmodule
